// File: rtl/sram_access_pkg.sv
// Shared bundle definitions for the SRAM access port and the arbiter's outstanding-request tag.
package sram_access_pkg;

    localparam int ID_W   = 4;
    localparam int BE_W   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    typedef struct packed {
        logic              valid;
        logic [ID_W-1:0]   id;
        logic              read_not_write;
        logic [BE_W-1:0]   byte_enable;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] write_data;
    } t_sram_access_req;

    typedef struct packed {
        logic              ack;
        logic              valid;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } t_sram_access_resp;

    typedef struct packed {
        logic            owner;
        logic [ID_W-1:0] id;
    } t_arb_tag;

    localparam t_sram_access_req REQ_RESET = '{
        valid:          1'b0,
        id:             '0,
        read_not_write: 1'b0,
        byte_enable:    8'hf,
        address:        '0,
        write_data:     '0
    };

endpackage

// File: rtl/sram_arb_tag_fifo.sv
// Tag FIFO of granted-but-unanswered requests; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module sram_arb_tag_fifo
    import sram_access_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     clk__enable,
    input  logic     reset_n,
    input  logic     push,
    input  t_arb_tag push_tag,
    input  logic     pop,
    output t_arb_tag head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    t_arb_tag    mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clk__enable) begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (clk__enable && push) mem[wr_ptr[AW-1:0]] <= push_tag;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/sram_access_arbiter.sv
// Two-requester arbiter onto one registered SRAM access port with in-order response routing.
// Build option SRAM_ARB_FIXED_PRIORITY_EN: requester 0 always wins contention (default round-robin).
module sram_access_arbiter
    import sram_access_pkg::*;
#(
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic              clk,
    input  logic              clk__enable,
    input  logic              reset_n,

    input  logic              req0_sram_access_req__valid,
    input  logic [ID_W-1:0]   req0_sram_access_req__id,
    input  logic              req0_sram_access_req__read_not_write,
    input  logic [BE_W-1:0]   req0_sram_access_req__byte_enable,
    input  logic [ADDR_W-1:0] req0_sram_access_req__address,
    input  logic [DATA_W-1:0] req0_sram_access_req__write_data,
    output logic              req0_sram_access_resp__ack,
    output logic              req0_sram_access_resp__valid,
    output logic [ID_W-1:0]   req0_sram_access_resp__id,
    output logic [DATA_W-1:0] req0_sram_access_resp__data,

    input  logic              req1_sram_access_req__valid,
    input  logic [ID_W-1:0]   req1_sram_access_req__id,
    input  logic              req1_sram_access_req__read_not_write,
    input  logic [BE_W-1:0]   req1_sram_access_req__byte_enable,
    input  logic [ADDR_W-1:0] req1_sram_access_req__address,
    input  logic [DATA_W-1:0] req1_sram_access_req__write_data,
    output logic              req1_sram_access_resp__ack,
    output logic              req1_sram_access_resp__valid,
    output logic [ID_W-1:0]   req1_sram_access_resp__id,
    output logic [DATA_W-1:0] req1_sram_access_resp__data,

    output logic              sram_access_req__valid,
    output logic [ID_W-1:0]   sram_access_req__id,
    output logic              sram_access_req__read_not_write,
    output logic [BE_W-1:0]   sram_access_req__byte_enable,
    output logic [ADDR_W-1:0] sram_access_req__address,
    output logic [DATA_W-1:0] sram_access_req__write_data,

    input  logic              sram_access_resp__ack,
    input  logic              sram_access_resp__valid,
    input  logic [ID_W-1:0]   sram_access_resp__id,
    input  logic [DATA_W-1:0] sram_access_resp__data,

    output logic              resp_orphan_err
);

    t_sram_access_req up_req [2];
    t_sram_access_req down_q;
    t_arb_tag         push_tag;
    t_arb_tag         head;

    logic        last_grant;
    logic        winner;
    logic        grant;
    logic        pop;
    logic        slot_free;
    logic        can_grant;
    logic        fifo_full;
    logic        fifo_empty;
    logic        orphan_q;
    logic [1:0]  resp_valid_q;
    logic [ID_W-1:0]   resp_id_q   [2];
    logic [DATA_W-1:0] resp_data_q [2];

    // Downstream ids encode only the owner; the upstream id travels in the tag FIFO.
    logic unused_resp_id;
    assign unused_resp_id = ^sram_access_resp__id;

    assign up_req[0] = {req0_sram_access_req__valid, req0_sram_access_req__id,
                        req0_sram_access_req__read_not_write, req0_sram_access_req__byte_enable,
                        req0_sram_access_req__address, req0_sram_access_req__write_data};
    assign up_req[1] = {req1_sram_access_req__valid, req1_sram_access_req__id,
                        req1_sram_access_req__read_not_write, req1_sram_access_req__byte_enable,
                        req1_sram_access_req__address, req1_sram_access_req__write_data};

    always_comb begin
        slot_free = !down_q.valid || sram_access_resp__ack;
        pop       = sram_access_resp__valid && !fifo_empty;
        // A same-cycle pop frees a FIFO entry, so a full FIFO does not block the grant.
        can_grant = reset_n && clk__enable && slot_free && (!fifo_full || pop);
        winner    = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
        winner = !up_req[0].valid;
`else
        if (up_req[0].valid && up_req[1].valid) winner = !last_grant;
        else                                    winner = up_req[1].valid;
`endif
        grant    = can_grant && (up_req[0].valid || up_req[1].valid);
        push_tag = {winner, up_req[winner].id};
    end

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    assign req0_sram_access_resp__ack = grant && !winner;
    assign req1_sram_access_resp__ack = grant && winner;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            down_q         <= REQ_RESET;
            last_grant     <= 1'b1;
            resp_valid_q   <= 2'b00;
            resp_id_q[0]   <= '0;
            resp_id_q[1]   <= '0;
            resp_data_q[0] <= '0;
            resp_data_q[1] <= '0;
            orphan_q       <= 1'b0;
        end else if (clk__enable) begin
            if (grant) begin
                down_q       <= up_req[winner];
                down_q.valid <= 1'b1;
                down_q.id    <= {{(ID_W-1){1'b0}}, winner};
                last_grant   <= winner;
            end else if (sram_access_resp__ack) begin
                down_q.valid <= 1'b0;
            end

            resp_valid_q <= 2'b00;
            if (pop) begin
                resp_valid_q[head.owner] <= 1'b1;
                resp_id_q[head.owner]    <= head.id;
                resp_data_q[head.owner]  <= sram_access_resp__data;
            end
            if (sram_access_resp__valid && fifo_empty) orphan_q <= 1'b1;
        end
    end

    sram_arb_tag_fifo #(
        .DEPTH (OUTSTANDING_DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .clk__enable (clk__enable),
        .reset_n     (reset_n),
        .push        (grant),
        .push_tag    (push_tag),
        .pop         (pop),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    assign sram_access_req__valid          = down_q.valid;
    assign sram_access_req__id             = down_q.id;
    assign sram_access_req__read_not_write = down_q.read_not_write;
    assign sram_access_req__byte_enable    = down_q.byte_enable;
    assign sram_access_req__address        = down_q.address;
    assign sram_access_req__write_data     = down_q.write_data;

    assign req0_sram_access_resp__valid = resp_valid_q[0];
    assign req0_sram_access_resp__id    = resp_id_q[0];
    assign req0_sram_access_resp__data  = resp_data_q[0];
    assign req1_sram_access_resp__valid = resp_valid_q[1];
    assign req1_sram_access_resp__id    = resp_id_q[1];
    assign req1_sram_access_resp__data  = resp_data_q[1];

    assign resp_orphan_err = orphan_q;

endmodule
